// File: rtl/button_conditioner.sv
// Debounced push-button conditioner: level, press/release strobes and optional long-press strobe.
// Long-press support is compiled in only when BUTTON_LONG_PRESS_EN is defined.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 100000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t        state;
  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // s2 is the synchronized button (btn_sync); the FSM never looks at btn directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      s1            <= 1'b0;
      s2            <= 1'b0;
      cnt           <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      s1            <= btn;
      s2            <= s1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (s2) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!s2) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            state       <= HELD;
            btn_level   <= 1'b1;
            press_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!s2) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (s2) begin
            state <= HELD;
          end else if (cnt == CNT_LAST) begin
            state         <= IDLE;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BUTTON_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_CYCLES);

  logic [HW-1:0] hold_cnt;

  // Saturating at LONG_CYCLES guarantees a single strobe per accepted press.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt   <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (state == RELEASE_WAIT && !s2 && cnt == CNT_LAST) begin
        hold_cnt <= '0;
      end else if (state == HELD && hold_cnt != HOLD_SAT) begin
        hold_cnt <= hold_cnt + 1'b1;
        if (hold_cnt == HOLD_LAST) begin
          long_press <= 1'b1;
        end
      end
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus random bouncing
// against a run-length reference model of the debounce rules.
module tb_button_conditioner;
  localparam int D = 4;
  localparam int L = 10;

  logic clk = 1'b0;
  logic reset;
  logic btn;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic long_press;

  int tests = 0;
  int fails = 0;

  // Reference model state: synchronizer delay, accepted level, length of the
  // current run of samples disagreeing with it, and cycles spent firmly held.
  int m_s1 = 0, m_s2 = 0, acc = 0, run = 0, hold = 0;
  int e_level = 0, e_press = 0, e_rel = 0, e_long = 0;
  int n_press = 0, n_rel = 0;

  button_conditioner #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
    .clk(clk),
    .reset(reset),
    .btn(btn),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_press(long_press)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_edge(input int b, input int r);
    int seen;
    int was_held;
    if (r != 0) begin
      m_s1 = 0; m_s2 = 0; acc = 0; run = 0; hold = 0;
      e_level = 0; e_press = 0; e_rel = 0; e_long = 0;
    end else begin
      seen     = m_s2;
      was_held = (acc == 1 && run == 0) ? 1 : 0;
      e_press  = 0; e_rel = 0; e_long = 0;
      if (seen != acc) begin
        run++;
        if (run == D + 1) begin
          acc = seen;
          run = 0;
          if (acc == 1) e_press = 1;
          else begin
            e_rel = 1;
            hold  = 0;
          end
        end
      end else begin
        run = 0;
      end
`ifdef BUTTON_LONG_PRESS_EN
      if (was_held == 1) begin
        hold++;
        if (hold == L) e_long = 1;
      end
`endif
      e_level = acc;
      m_s2 = m_s1;
      m_s1 = b;
    end
  endtask

  task automatic step(input logic b, input logic r);
    @(negedge clk);
    btn   = b;
    reset = r;
    @(posedge clk);
    model_edge(int'(b), int'(r));
    #1;
    check("btn_level", int'(btn_level), e_level);
    check("press_pulse", int'(press_pulse), e_press);
    check("release_pulse", int'(release_pulse), e_rel);
    check("long_press", int'(long_press), e_long);
    check("pulse_overlap", int'(press_pulse & release_pulse), 0);
    if (press_pulse) n_press++;
    if (release_pulse) n_rel++;
    if (press_pulse || release_pulse) check("pulse_alternation", n_press - n_rel, press_pulse ? 1 : 0);
  endtask

  initial begin
    int p_edge, l_edge, r_edge, n_long, cnt_p, cnt_r, len, val;
    btn   = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    $display("[TB] reset held 3 cycles");

    // Clean press followed by a long hold.
    p_edge = -1; l_edge = -1; n_long = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0);
      if (press_pulse && p_edge < 0) p_edge = i;
      if (long_press) begin
        n_long++;
        if (l_edge < 0) l_edge = i;
      end
    end
    check("clean_press_edge", p_edge, D + 2);
`ifdef BUTTON_LONG_PRESS_EN
    check("long_press_edge", l_edge, D + 2 + L);
    check("long_press_count", n_long, 1);
`else
    check("long_press_count", n_long, 0);
`endif
    $display("[TB] clean press edge=%0d long edge=%0d", p_edge, l_edge);

    // Release glitch while held, then a steady release.
    cnt_r = 0;
    for (int i = 0; i < 2; i++) begin step(1'b0, 1'b0); if (release_pulse) cnt_r++; end
    for (int i = 0; i < 5; i++) begin step(1'b1, 1'b0); if (release_pulse) cnt_r++; end
    check("glitch_no_release", cnt_r, 0);
    check("glitch_level", int'(btn_level), 1);
    r_edge = -1;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0);
      if (release_pulse && r_edge < 0) r_edge = i;
    end
    check("release_edge", r_edge, D + 2);
    $display("[TB] release glitch rejected, release edge=%0d", r_edge);

    // Press bounce: 3 high, 2 low, then steady high.
    cnt_p = 0;
    for (int i = 0; i < 3; i++) begin step(1'b1, 1'b0); if (press_pulse) cnt_p++; end
    for (int i = 0; i < 2; i++) begin step(1'b0, 1'b0); if (press_pulse) cnt_p++; end
    check("bounce_no_press", cnt_p, 0);
    p_edge = -1;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0);
      if (press_pulse) begin cnt_p++; if (p_edge < 0) p_edge = i; end
    end
    check("bounce_press_edge", p_edge, D + 2);
    check("bounce_press_count", cnt_p, 1);
    $display("[TB] bounce rejected, press edge=%0d", p_edge);

    // Reset at the edge where the press would be accepted.
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
    for (int i = 0; i < D + 2; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("rst_mid_press", int'(press_pulse), 0);
    check("rst_mid_level", int'(btn_level), 0);
    p_edge = -1;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0);
      if (press_pulse && p_edge < 0) p_edge = i;
    end
    check("rst_repress_edge", p_edge, D + 2);
    $display("[TB] reset mid-press, re-press edge=%0d", p_edge);

    // Random bouncing with occasional long holds and resets.
    val = 0;
    for (int k = 0; k < 600; k++) begin
      val = 1 - val;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 30) : $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 299) == 0) begin
          step(1'(val), 1'b1);
          n_press = 0; n_rel = 0;
        end else begin
          step(1'(val), 1'b0);
        end
      end
    end
    $display("[TB] random phase done, presses=%0d releases=%0d", n_press, n_rel);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, giving the stable-sample count needed to accept an edge (10 ms at 100 MHz); legal range 1..2^24-1.
REQ-002 The block SHALL have parameter LONG_CYCLES, default 100000000, giving the HELD cycles before long_press (1 s at 100 MHz); legal range 1..2^28-1.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock; the only clock.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port btn, input, 1 bit: raw asynchronous button pin, active-high.
REQ-006 The block SHALL have port btn_level, output, 1 bit: debounced button level.
REQ-007 The block SHALL have port press_pulse, output, 1 bit: one-cycle strobe on each accepted press.
REQ-008 The block SHALL have port release_pulse, output, 1 bit: one-cycle strobe on each accepted release.
REQ-009 The block SHALL have port long_press, output, 1 bit: one-cycle strobe when a press has been held LONG_CYCLES.

Function
REQ-010 btn SHALL pass through a 2-flop synchronizer (s1, s2) before use; s2 is btn_sync.
REQ-011 The FSM SHALL have states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT, plus one debounce counter sized $clog2(DEBOUNCE_CYCLES+1).
REQ-012 In IDLE with btn_sync=1, the FSM SHALL go to PRESS_WAIT with the counter cleared to 0.
REQ-013 In PRESS_WAIT with btn_sync=0, the FSM SHALL return to IDLE and emit no pulse (bounce rejected).
REQ-014 In PRESS_WAIT with btn_sync=1 and counter=DEBOUNCE_CYCLES-1, the FSM SHALL go to HELD; otherwise the counter SHALL increment.
REQ-015 In HELD with btn_sync=0, the FSM SHALL go to RELEASE_WAIT with the counter cleared.
REQ-016 In RELEASE_WAIT with btn_sync=1, the FSM SHALL return to HELD and emit no pulse.
REQ-017 In RELEASE_WAIT with btn_sync=0 and counter=DEBOUNCE_CYCLES-1, the FSM SHALL go to IDLE; otherwise the counter SHALL increment.
REQ-018 All outputs SHALL be registered; btn_level SHALL be 1 exactly in HELD and RELEASE_WAIT.
REQ-019 press_pulse SHALL be high for exactly the one cycle following the PRESS_WAIT->HELD edge; release_pulse likewise for RELEASE_WAIT->IDLE.
REQ-020 With edge 0 the first clk edge sampling btn=1 and btn held steady, press_pulse SHALL go high after edge DEBOUNCE_CYCLES+2 and btn_level after the same edge; release latency SHALL be symmetric.
REQ-021 press_pulse and release_pulse SHALL never be high in the same cycle and SHALL strictly alternate, press first after reset.
REQ-022 The debounce counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.

Reset
REQ-023 When reset is high at a clk edge, the block SHALL force the FSM to IDLE, clear s1, s2 and all counters, and drive btn_level, press_pulse, release_pulse and long_press to 0 after that edge.
REQ-024 Reset SHALL take priority over every transition, including the cycle in which a pulse would fire; the suppressed pulse SHALL NOT be emitted later.
REQ-025 If btn is held high through reset release, the block SHALL treat the press as new and emit press_pulse after the full REQ-020 latency.

Configuration
REQ-026 Macro BUTTON_LONG_PRESS_EN SHALL control long-press support.
REQ-027 With BUTTON_LONG_PRESS_EN defined, a hold counter of $clog2(LONG_CYCLES+1) bits SHALL increment each HELD cycle, hold its value in RELEASE_WAIT, and clear on entry to IDLE.
REQ-028 With BUTTON_LONG_PRESS_EN defined, long_press SHALL strobe for one cycle when the hold counter reaches LONG_CYCLES-1, then the counter SHALL saturate, so at most one strobe occurs per accepted press.
REQ-029 With BUTTON_LONG_PRESS_EN undefined, the hold counter SHALL NOT exist, long_press SHALL be tied to 0, and all other behaviour SHALL be identical.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=10, macro defined unless noted)
REQ-030 Clean press: btn 0->1 at edge 0, held -> press_pulse and btn_level high after edge 6; press_pulse low after edge 7.
REQ-031 Bounce: btn high for 3 cycles, low for 2, then high steady -> no pulse during the bounce; exactly one press_pulse after the steady high meets the REQ-020 latency.
REQ-032 Release glitch: in HELD, btn low for 2 cycles then high -> no release_pulse, btn_level stays 1; a later steady low gives one release_pulse 6 edges after the first low sample.
REQ-033 Long press: hold 30 cycles past press_pulse -> exactly one long_press, 10 cycles after HELD entry; with the macro undefined, long_press stays 0 throughout.
REQ-034 Reset mid-operation: assert reset in the PRESS_WAIT cycle where counter=3 -> all outputs 0 and no press_pulse; with btn still high after reset, press_pulse fires after edge 6, counted from the first post-reset sample.
